// File: rtl/ifu_pkg.sv
// Shared sizing and FSM state type for the IFU miss/refill path.
package ifu_pkg;

  localparam int WAYS_NUM = 16;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;
  localparam int BEATS    = LINE_W / WORD_W;
  localparam int WAY_W    = $clog2(WAYS_NUM);
  localparam int BEAT_W   = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VICTIM = 3'd1,
    REQ    = 3'd2,
    FILL   = 3'd3,
    WRITE  = 3'd4
  } t_refill_state;

endpackage

// File: rtl/ifu_free_way_enc.sv
// Lowest-index invalid way finder; any_free is low only when every way is valid.
module ifu_free_way_enc #(
  parameter int WAYS_NUM = 16,
  localparam int WAY_W   = $clog2(WAYS_NUM)
) (
  input  logic [WAYS_NUM-1:0] valid_vec,
  output logic [WAY_W-1:0]    free_idx,
  output logic                any_free
);

  // Scan from the top down so the lowest invalid index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = WAY_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifu_refill_ctrl.sv
// I-cache miss handler: picks a victim way, fetches the line in beats, writes it back.
// Build option: IFU_REFILL_BYPASS_EN enables registered early-beat forwarding.
//
// state  | meaning
// IDLE   | waiting for a fetch miss, miss_ready high
// VICTIM | cache_miss pulse to the PLRU, victim way latched
// REQ    | line read request held until mem_req_ready
// FILL   | collecting response beats into the line buffer
// WRITE  | one-cycle fill strobe, valid bit of the victim set
module ifu_refill_ctrl #(
  parameter int WAYS_NUM = ifu_pkg::WAYS_NUM,
  parameter int ADDR_W   = ifu_pkg::ADDR_W,
  parameter int OFFSET_W = ifu_pkg::OFFSET_W,
  parameter int WORD_W   = ifu_pkg::WORD_W,
  parameter int LINE_W   = ifu_pkg::LINE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_valid,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         miss_ready,
  input  logic                         flush,
  output logic                         cache_miss,
  output logic                         cache_full,
  input  logic [$clog2(WAYS_NUM)-1:0]  evicted_cl,
  output logic                         mem_req_valid,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [WORD_W-1:0]            mem_rsp_data,
  output logic                         fill_we,
  output logic [$clog2(WAYS_NUM)-1:0]  fill_way,
  output logic [ADDR_W-OFFSET_W-1:0]   fill_tag,
  output logic [LINE_W-1:0]            fill_data,
  output logic                         fill_done,
  output logic                         bypass_valid,
  output logic [WORD_W-1:0]            bypass_data,
  output logic [WAYS_NUM-1:0]          valid_vec
);

  localparam int WAY_W  = $clog2(WAYS_NUM);
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int TAG_W  = ADDR_W - OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  import ifu_pkg::*;

  t_refill_state         state_q, state_d;
  logic [TAG_W-1:0]      tag_q;
  logic [WAY_W-1:0]      way_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [LINE_W-1:0]     line_q;
  logic [WAYS_NUM-1:0]   valid_vec_q;
  logic [WAY_W-1:0]      free_idx;
  logic                  any_free;
  logic                  accept;
  logic                  fill_beat;
  logic [WAYS_NUM-1:0]   way_onehot;

  // Offset bits select a word inside the line; the refill always fetches the whole line.
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  ifu_free_way_enc #(
    .WAYS_NUM (WAYS_NUM)
  ) u_free_way_enc (
    .valid_vec (valid_vec_q),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign accept     = (state_q == IDLE) && miss_valid;
  assign fill_beat  = (state_q == FILL) && mem_rsp_valid;
  assign way_onehot = WAYS_NUM'(1) << way_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid) state_d = VICTIM;
      VICTIM:  state_d = REQ;
      REQ:     if (mem_req_ready) state_d = FILL;
      FILL:    if (mem_rsp_valid && (beat_cnt_q == LAST_BEAT)) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready    = 1'b0;
    cache_miss    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    unique case (state_q)
      IDLE:    miss_ready    = 1'b1;
      VICTIM:  cache_miss    = 1'b1;
      REQ:     mem_req_valid = 1'b1;
      WRITE:   fill_we       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      way_q       <= '0;
      beat_cnt_q  <= '0;
      line_q      <= '0;
      valid_vec_q <= '0;
    end else begin
      if (accept) begin
        tag_q <= miss_addr[ADDR_W-1:OFFSET_W];
      end
      if (state_q == VICTIM) begin
        way_q <= any_free ? free_idx : evicted_cl;
      end
      if (fill_beat) begin
        for (int k = 0; k < BEATS; k++) begin
          if (beat_cnt_q == BEAT_W'(k)) begin
            line_q[k*WORD_W +: WORD_W] <= mem_rsp_data;
          end
        end
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (state_q == WRITE) begin
        beat_cnt_q <= '0;
      end
      // A flush racing the write still leaves the just-filled way valid.
      if (state_q == WRITE) begin
        valid_vec_q <= (flush ? '0 : valid_vec_q) | way_onehot;
      end else if (flush) begin
        valid_vec_q <= '0;
      end
    end
  end

  assign cache_full   = &valid_vec_q;
  assign valid_vec    = valid_vec_q;
  assign mem_req_addr = {tag_q, {OFFSET_W{1'b0}}};
  assign fill_way     = way_q;
  assign fill_tag     = tag_q;
  assign fill_data    = line_q;
  assign fill_done    = fill_we;

`ifdef IFU_REFILL_BYPASS_EN
  logic              bypass_valid_q;
  logic [WORD_W-1:0] bypass_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_valid_q <= 1'b0;
      bypass_data_q  <= '0;
    end else begin
      bypass_valid_q <= fill_beat;
      if (fill_beat) begin
        bypass_data_q <= mem_rsp_data;
      end
    end
  end

  assign bypass_valid = bypass_valid_q;
  assign bypass_data  = bypass_data_q;
`else
  assign bypass_valid = 1'b0;
  assign bypass_data  = '0;
`endif

endmodule

// File: tb/tb_ifu_refill_ctrl.sv
// Directed + randomized bench for ifu_refill_ctrl against a way-level reference model.
module tb_ifu_refill_ctrl;

`ifdef IFU_REFILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         flush;
  logic         cache_miss;
  logic         cache_full;
  logic [3:0]   evicted_cl;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         fill_we;
  logic [3:0]   fill_way;
  logic [27:0]  fill_tag;
  logic [127:0] fill_data;
  logic         fill_done;
  logic         bypass_valid;
  logic [31:0]  bypass_data;
  logic [15:0]  valid_vec;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] ref_valid;

  always #5 clk = ~clk;

  ifu_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .flush         (flush),
    .cache_miss    (cache_miss),
    .cache_full    (cache_full),
    .evicted_cl    (evicted_cl),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fill_we       (fill_we),
    .fill_way      (fill_way),
    .fill_tag      (fill_tag),
    .fill_data     (fill_data),
    .fill_done     (fill_done),
    .bypass_valid  (bypass_valid),
    .bypass_data   (bypass_data),
    .valid_vec     (valid_vec)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_miss_ready"},    miss_ready,    1);
    chk({pfx, "_cache_miss"},    cache_miss,    0);
    chk({pfx, "_cache_full"},    cache_full,    0);
    chk({pfx, "_mem_req_valid"}, mem_req_valid, 0);
    chk({pfx, "_mem_req_addr"},  mem_req_addr,  0);
    chk({pfx, "_fill_we"},       fill_we,       0);
    chk({pfx, "_fill_done"},     fill_done,     0);
    chk({pfx, "_fill_way"},      fill_way,      0);
    chk({pfx, "_fill_tag"},      fill_tag,      0);
    chk({pfx, "_fill_data"},     fill_data,     0);
    chk({pfx, "_bypass_valid"},  bypass_valid,  0);
    chk({pfx, "_bypass_data"},   bypass_data,   0);
    chk({pfx, "_valid_vec"},     valid_vec,     0);
  endtask

  // One complete refill; expected victim comes from the valid-bit model.
  task automatic refill(input logic [31:0] addr, input logic [3:0] evict, input int rdy_dly,
                        input int gap, input bit flush_wr, input logic [127:0] line);
    logic [3:0]  exp_way;
    logic [27:0] tag;
    bit          full;
    tag     = addr[31:4];
    full    = (ref_valid == 16'hFFFF);
    exp_way = evict;
    if (!full) begin
      for (int i = 15; i >= 0; i--) if (!ref_valid[i]) exp_way = 4'(i);
    end

    chk("idle_ready", miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    evicted_cl = evict;
    step();
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    chk("cache_miss", cache_miss, 1);
    chk("cache_full", cache_full, full);
    chk("victim_no_req", mem_req_valid, 0);
    step();
    evicted_cl = 4'($urandom);
    chk("req_no_miss_pulse", cache_miss, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      chk("req_valid_hold", mem_req_valid, 1);
      chk("req_addr_hold", mem_req_addr, {tag, 4'h0});
      chk("busy_not_ready", miss_ready, 0);
      miss_valid = 1'b1;
      step();
    end
    miss_valid = 1'b0;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, {tag, 4'h0});
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("fill_no_req", mem_req_valid, 0);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        chk("gap_no_we", fill_we, 0);
        step();
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line[k*32 +: 32];
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      chk("byp_valid", bypass_valid, BYP);
      chk("byp_data", bypass_data, BYP ? line[k*32 +: 32] : 32'h0);
      if (k < 3) chk("no_early_we", fill_we, 0);
    end
    chk("fill_we", fill_we, 1);
    chk("fill_done", fill_done, 1);
    chk("fill_way", fill_way, exp_way);
    chk("fill_tag", fill_tag, tag);
    chk("fill_data", fill_data, line);
    flush = flush_wr;
    step();
    flush = 1'b0;
    ref_valid = (flush_wr ? 16'h0 : ref_valid) | (16'h1 << exp_way);
    chk("valid_vec", valid_vec, ref_valid);
    chk("ready_after", miss_ready, 1);
    chk("we_one_cycle", fill_we, 0);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst           = 1'b1;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    flush         = 1'b0;
    evicted_cl    = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    ref_valid     = '0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Stray beats in IDLE must be ignored.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      step();
      chk("stray_ready", miss_ready, 1);
      chk("stray_no_we", fill_we, 0);
      chk("stray_no_byp", bypass_valid, 0);
    end
    mem_rsp_valid = 1'b0;

    // Cold miss, minimum latency.
    refill(32'h0000_1234, 4'd5, 0, 0, 1'b0,
           {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000});
    chk("cold_valid", valid_vec, 16'h0001);

    // Fill the rest of the cache; one long backpressure and one gapped refill.
    for (int i = 1; i < 16; i++) begin
      int rd, gp;
      rd = (i == 1) ? 5 : int'($urandom_range(0, 2));
      gp = (i == 2) ? 3 : int'($urandom_range(0, 1));
      refill($urandom, 4'($urandom), rd, gp, 1'b0, rand_line());
    end
    chk("full_flag", cache_full, 1);

    // Full cache: victim comes from the PLRU.
    refill($urandom, 4'd9, 1, 0, 1'b0, rand_line());
    chk("full_valid", valid_vec, 16'hFFFF);

    flush = 1'b1;
    step();
    flush = 1'b0;
    ref_valid = '0;
    chk("flush_idle", valid_vec, 16'h0000);
    chk("flush_not_full", cache_full, 0);

    // Flush racing the write of way 3.
    for (int i = 0; i < 3; i++) refill($urandom, 4'($urandom), 0, 0, 1'b0, rand_line());
    refill($urandom, 4'($urandom), 0, 1, 1'b1, rand_line());
    chk("flush_race", valid_vec, 16'h0008);

    // Reset in the middle of FILL.
    miss_valid = 1'b1;
    miss_addr  = $urandom;
    step();
    miss_valid = 1'b0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_valid = '0;
    chk_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_no_we", fill_we, 0);
      chk("midrst_idle", miss_ready, 1);
    end
    mem_rsp_valid = 1'b0;

    refill($urandom, 4'($urandom), 2, 2, 1'b0, rand_line());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
